// File: rtl/prog_loader.sv
// Serial program loader: receives a framed byte stream from a host and writes
// it into CPU program RAM while holding the CPU in reset.
module prog_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned RST_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       prog_mode,
    output logic [3:0] ram_addr,
    output logic [7:0] ram_data,
    output logic       ram_we,
    output logic       cpu_rst_n,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] COUNT   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] CHECK   = 3'd4;
    localparam logic [2:0] RELEASE = 3'd5;

    localparam logic [3:0] HOLD_LAST = 4'(RST_HOLD - 1);

    logic [2:0] state_q, state_d;
    logic       prog_q, prog_d;
    logic [4:0] idx_q, idx_d;
    logic [4:0] n_q, n_d;
    logic [7:0] data_q, data_d;
    logic       we_q, we_d;
    logic       cpu_q, cpu_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] sum_q, sum_d;
    logic [3:0] hold_q, hold_d;
    logic       acc;

    assign in_ready  = (state_q != WRITE) && (state_q != RELEASE);
    assign acc       = in_valid && in_ready;
    assign prog_mode = prog_q;
    assign ram_addr  = idx_q[3:0];
    assign ram_data  = data_q;
    assign ram_we    = we_q;
    assign cpu_rst_n = cpu_q;
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        idx_d   = idx_q;
        n_d     = n_q;
        data_d  = data_q;
        we_d    = 1'b0;
        cpu_d   = cpu_q;
        done_d  = 1'b0;
        err_d   = err_q;
        sum_d   = sum_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (acc && in_data == SYNC_BYTE) begin
                    state_d = COUNT;
                    prog_d  = 1'b1;
                    cpu_d   = 1'b0;
                    err_d   = 1'b0;
                    sum_d   = 8'd0;
                end
            end
            COUNT: begin
                if (acc) begin
                    // a zero count field encodes a full 16-byte image
                    n_d     = (in_data[3:0] == 4'd0) ? 5'd16
                                                     : {1'b0, in_data[3:0]};
                    idx_d   = 5'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (acc) begin
                    data_d  = in_data;
                    sum_d   = sum_q + in_data;
                    we_d    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                idx_d   = idx_q + 5'd1;
                state_d = (idx_q + 5'd1 == n_q) ? CHECK : DATA;
            end
            CHECK: begin
                if (acc) begin
                    prog_d = 1'b0;
                    if (in_data == sum_q) begin
                        state_d = RELEASE;
                        hold_d  = 4'd0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            RELEASE: begin
                if (hold_q == HOLD_LAST) begin
                    cpu_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            prog_q  <= 1'b0;
            idx_q   <= 5'd0;
            n_q     <= 5'd0;
            data_q  <= 8'd0;
            we_q    <= 1'b0;
            cpu_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sum_q   <= 8'd0;
            hold_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            prog_q  <= prog_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            data_q  <= data_d;
            we_q    <= we_d;
            cpu_q   <= cpu_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes are queued by the
// stimulus thread and checked by an independent monitor.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       prog_mode;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic       cpu_rst_n;
    logic       done;
    logic       err;

    localparam int HOLD = 2;

    int total = 0;
    int bad = 0;
    int done_seen = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mon_e;

    prog_loader #(.SYNC_BYTE(8'hA5), .RST_HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .prog_mode(prog_mode), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_we(ram_we), .cpu_rst_n(cpu_rst_n),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ram_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected write: addr %0h data %0h",
                         ram_addr, ram_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ram write", {20'd0, ram_addr, ram_data}, {20'd0, mon_e});
                chk("ready during write", {31'd0, in_ready}, 32'd0);
            end
        end
        if (done) done_seen++;
    end

    // called at a falling edge; returns at the falling edge after acceptance
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send timeout: byte %0h not accepted", b);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic frame(input logic [7:0] c, input int n,
                         input logic [7:0] base, input logic [7:0] step,
                         input logic [7:0] cks, input bit good);
        logic [7:0] d;
        int lows = 0;
        int d0;
        send(8'hA5);
        chk("prog_mode after sync", {31'd0, prog_mode}, 32'd1);
        chk("cpu_rst_n after sync", {31'd0, cpu_rst_n}, 32'd0);
        chk("err cleared by sync", {31'd0, err}, 32'd0);
        send(c);
        for (int i = 0; i < n; i++) begin
            d = base + 8'(i) * step;
            exp_q.push_back({4'(i), d});
            send(d);
        end
        send(cks);
        in_valid = 1'b0;
        chk("prog_mode after cks", {31'd0, prog_mode}, 32'd0);
        chk("writes drained", exp_q.size(), 32'd0);
        d0 = done_seen;
        if (good) begin
            while (!cpu_rst_n && lows < 20) begin
                lows++;
                @(negedge clk);
            end
            chk("cpu_rst_n low cycles", lows, HOLD);
            chk("done pulse", {31'd0, done}, 32'd1);
            chk("err good frame", {31'd0, err}, 32'd0);
            @(negedge clk);
            chk("done one cycle", {31'd0, done}, 32'd0);
            chk("done count", done_seen - d0, 32'd1);
        end else begin
            chk("err set", {31'd0, err}, 32'd1);
            repeat (5) @(negedge clk);
            chk("cpu_rst_n held", {31'd0, cpu_rst_n}, 32'd0);
            chk("err sticky", {31'd0, err}, 32'd1);
            chk("no done on bad", done_seen - d0, 32'd0);
        end
    endtask

    initial begin
        int d0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset outs",
            {24'd0, prog_mode, ram_we, cpu_rst_n, done, err, in_ready, 2'd0},
            {24'd0, 8'b0010_0100});
        chk("reset addr/data", {20'd0, ram_addr, ram_data}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready after reset", {31'd0, in_ready}, 32'd1);

        // junk then minimal frame, in_valid held high throughout
        send(8'h00);
        chk("junk 00 ignored", {31'd0, prog_mode}, 32'd0);
        send(8'hFF);
        chk("junk FF ignored", {31'd0, prog_mode}, 32'd0);
        frame(8'h01, 1, 8'h7F, 8'h00, 8'h7F, 1'b1);

        frame(8'h03, 3, 8'h11, 8'h11, 8'h66, 1'b1);
        frame(8'h00, 16, 8'h01, 8'h01, 8'h88, 1'b1);
        frame(8'h02, 2, 8'h10, 8'h10, 8'h31, 1'b0);
        frame(8'h03, 3, 8'h11, 8'h11, 8'h66, 1'b1);

        // reset right after the second data byte of a 4-byte frame
        d0 = done_seen;
        send(8'hA5);
        send(8'h04);
        exp_q.push_back({4'h0, 8'h44});
        send(8'h44);
        exp_q.push_back({4'h1, 8'h55});
        send(8'h55);
        #2 rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midframe reset outs",
            {24'd0, prog_mode, ram_we, cpu_rst_n, done, err, in_ready, 2'd0},
            {24'd0, 8'b0010_0100});
        chk("midframe reset addr/data", {20'd0, ram_addr, ram_data}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready after midframe reset", {31'd0, in_ready}, 32'd1);
        chk("no done after abort", done_seen - d0, 32'd0);
        chk("abort writes drained", exp_q.size(), 32'd0);
        frame(8'h03, 3, 8'h11, 8'h11, 8'h66, 1'b1);

        repeat (3) @(negedge clk);
        chk("final queue empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
